// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset instruction and the
// fetch FSM state type for the instruction-fetch front end.
package fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem read port, decode stall/redirect inputs
// and the IF/ID output bundle of the fetch stage.
interface fetch_if #(
  parameter int AW = fetch_pkg::ADDR_W,
  parameter int IW = fetch_pkg::INSTR_W
);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          id_stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          if_id_valid;
  logic [IW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic [AW-1:0] if_id_pc_plus4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  id_stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output if_id_pc_plus4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output id_stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_pc_plus4
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {valid, instr, pc} register.
// Priority: flush > load > unload. Data holds when emptied.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int IW = INSTR_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          unload_i,
  input  logic [IW-1:0] instr_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q;
  logic [AW-1:0] pc_q;

  // next valid: flush wins, then load, then unload
  always_comb begin
    valid_d = valid_q;
    unique case (1'b1)
      flush_i:  valid_d = 1'b0;
      load_i:   valid_d = 1'b1;
      unload_i: valid_d = 1'b0;
      default:  valid_d = valid_q;
    endcase
  end

  // entry register; payload only moves on load
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= IW'(NOP_INSTR);
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i && !flush_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, 1-cycle imem issue, skid + IF/ID.
// FETCH_PERF_EN adds perf_fetched/perf_squashed counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic        SysCLK,
  input  logic        SysRST,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [15:0] perf_squashed
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_vld_q;
  logic [ADDR_W-1:0] infl_pc_q;

  logic redir, hold, issue, ret;

  logic               skid_vld, skid_ld, skid_unld;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  logic               ifid_vld, ifid_ld, ifid_unld;
  logic [INSTR_W-1:0] ifid_instr, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc, ifid_pc_d;
  logic [ADDR_W-1:0]  plus4_q;

  assign redir = bus.redirect_valid;
  assign hold  = bus.id_stall && ifid_vld;
  assign ret   = infl_vld_q && !redir;
  assign issue = (state_q == RUN) && !skid_vld
               && !hold && !redir;

  // BOOT lasts exactly one edge after reset release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // redirect beats sequential advance
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redir:   pc_d = bus.redirect_pc;
      issue:   pc_d = pc_q + STEP;
      default: pc_d = pc_q;
    endcase
  end

  // IF/ID takes the older skid word first, else the return
  always_comb begin
    ifid_ld      = !redir && !hold && (skid_vld || ret);
    ifid_unld    = !redir && !hold && !skid_vld && !ret;
    ifid_instr_d = skid_vld ? skid_instr : bus.imem_rdata;
    ifid_pc_d    = skid_vld ? skid_pc    : infl_pc_q;
    skid_ld      = ret && (hold || skid_vld);
    skid_unld    = !redir && !hold && skid_vld && !ret;
  end

  // state, PC and the single in-flight request tag
  always_ff @(posedge SysCLK or negedge SysRST) begin
    if (!SysRST) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      infl_vld_q <= 1'b0;
      infl_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      infl_vld_q <= issue;
      if (issue) infl_pc_q <= pc_q;
    end
  end

  // pc_plus4 is registered so it clears to 0 on reset
  always_ff @(posedge SysCLK or negedge SysRST) begin
    if (!SysRST) plus4_q <= '0;
    else if (ifid_ld) plus4_q <= ifid_pc_d + STEP;
  end

  fetch_skid_buf #(
    .AW (ADDR_W),
    .IW (INSTR_W)
  ) u_skid (
    .clk_i    (SysCLK),
    .rst_ni   (SysRST),
    .flush_i  (redir),
    .load_i   (skid_ld),
    .unload_i (skid_unld),
    .instr_i  (bus.imem_rdata),
    .pc_i     (infl_pc_q),
    .valid_o  (skid_vld),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  fetch_skid_buf #(
    .AW (ADDR_W),
    .IW (INSTR_W)
  ) u_ifid (
    .clk_i    (SysCLK),
    .rst_ni   (SysRST),
    .flush_i  (redir),
    .load_i   (ifid_ld),
    .unload_i (ifid_unld),
    .instr_i  (ifid_instr_d),
    .pc_i     (ifid_pc_d),
    .valid_o  (ifid_vld),
    .instr_o  (ifid_instr),
    .pc_o     (ifid_pc)
  );

  assign bus.imem_req       = issue;
  assign bus.imem_addr      = pc_q;
  assign bus.if_id_valid    = ifid_vld;
  assign bus.if_id_instr    = ifid_instr;
  assign bus.if_id_pc       = ifid_pc;
  assign bus.if_id_pc_plus4 = plus4_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fet_q;
  logic [15:0] sq_q;
  logic [1:0]  drop;
  logic [16:0] sq_sum;

  assign drop   = {1'b0, infl_vld_q} + {1'b0, skid_vld};
  assign sq_sum = {1'b0, sq_q} + 17'(drop);

  // saturating load and squash counters
  always_ff @(posedge SysCLK or negedge SysRST) begin
    if (!SysRST) begin
      fet_q <= '0;
      sq_q  <= '0;
    end else begin
      if (ifid_ld && fet_q != '1) fet_q <= fet_q + 32'd1;
      if (redir) sq_q <= sq_sum[16] ? '1 : sq_sum[15:0];
    end
  end

  assign perf_fetched  = fet_q;
  assign perf_squashed = sq_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random stall/redirect stimulus checked
// against a queue-based fetch model with synthetic memory.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic SysCLK = 1'b0;
  logic SysRST = 1'b0;

  fetch_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_squashed;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .SysCLK (SysCLK),
    .SysRST (SysRST),
    .bus    (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  always #5 SysCLK = ~SysCLK;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // synchronous instruction SRAM, garbage when not read
  always @(posedge SysCLK) begin
    if (bus.imem_req) bus.imem_rdata <= mem_word(bus.imem_addr);
    else bus.imem_rdata <= $urandom;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // model: words fetched but not yet in IF/ID, with issue cycle
  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } ent_t;

  ent_t        q[$];
  bit          m_run;
  bit          m_vld;
  logic [31:0] m_pc;
  logic [31:0] m_ifpc;
  int          cyc;
  int          m_fetched;
  int          m_squashed;

  task automatic m_reset();
    q.delete();
    m_run      = 0;
    m_vld      = 0;
    m_pc       = 32'h0;
    m_ifpc     = 32'h0;
    m_fetched  = 0;
    m_squashed = 0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, {31'b0, bus.if_id_valid}, 32'h0);
    chk({tag, "_instr"}, bus.if_id_instr, NOP_INSTR);
    chk({tag, "_pc"}, bus.if_id_pc, 32'h0);
    chk({tag, "_pc4"}, bus.if_id_pc_plus4, 32'h0);
    chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'h0);
`ifdef FETCH_PERF_EN
    chk({tag, "_pf"}, perf_fetched, 32'h0);
    chk({tag, "_ps"}, {16'h0, perf_squashed}, 32'h0);
`endif
  endtask

  // one cycle: drive after negedge, check, advance model
  task automatic step(bit stall, bit redir, logic [31:0] rpc);
    bit parked;
    bit exp_req;
    bus.id_stall       = stall;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    parked  = (q.size() > 0) && (q[0].cyc <= cyc - 2);
    exp_req = m_run && !redir && !(stall && m_vld) && !parked;
    chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, m_vld});
    if (m_vld) begin
      chk("if_id_pc", bus.if_id_pc, m_ifpc);
      chk("if_id_instr", bus.if_id_instr, mem_word(m_ifpc));
      chk("if_id_pc4", bus.if_id_pc_plus4, m_ifpc + 32'd4);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_squashed", {16'h0, perf_squashed},
        32'(m_squashed));
`endif
    if (redir) begin
      m_squashed += q.size();
      q.delete();
      m_vld = 0;
      m_pc  = rpc;
    end else begin
      if (!m_vld || !stall) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
          m_ifpc = q[0].pc;
          void'(q.pop_front());
          m_vld = 1;
          m_fetched++;
        end else begin
          m_vld = 0;
        end
      end
      if (exp_req) begin
        q.push_back('{pc: m_pc, cyc: cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_run = 1;
    cyc++;
    @(negedge SysCLK);
  endtask

  task automatic rnd_steps(int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           $urandom & 32'hFFFF_FFFC);
  endtask

  initial begin
    cyc = 0;
    bus.id_stall       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    m_reset();
    repeat (3) @(negedge SysCLK);
    chk_reset("por");
    SysRST = 1'b1;

    repeat (5) step(0, 0, 32'h0);
    repeat (3) step(1, 0, 32'h0);
    repeat (6) step(0, 0, 32'h0);

    step(0, 1, 32'h0000_0100);
    repeat (6) step(0, 0, 32'h0);

    step(1, 1, 32'h0000_0200);
    repeat (6) step(0, 0, 32'h0);

    step(0, 1, 32'hFFFF_FFF8);
    repeat (6) step(0, 0, 32'h0);

    rnd_steps(400);

    #3 SysRST = 1'b0;
    #1 chk_reset("async");
    m_reset();
    @(negedge SysCLK);
    @(negedge SysCLK);
    SysRST = 1'b1;
    repeat (6) step(0, 0, 32'h0);
    rnd_steps(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
